// File: rtl/expfn_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : expfn_out_buffer
//  Purpose  : Output buffer for expfn_pipelined. A valid shift register
//             follows real samples through the upstream pipeline. Each result
//             is converted from unsigned Q31.16 to sign-magnitude Q15.16,
//             saturating when it does not fit. Results are queued in a FIFO
//             and presented on a valid/ready interface. A credit count limits
//             in_ready so that a result is never dropped.
//  Ports    : clock       - rising-edge clock
//             reset       - asynchronous active-low reset
//             in_valid    - upstream drives a real sample this cycle
//             in_ready    - upstream may present a sample this cycle
//             exp_out     - expfn_pipelined result, unsigned Q31.16
//             out_valid   - FIFO head is valid
//             out_ready   - consumer takes the head this cycle
//             out_data    - head result, sign-magnitude Q15.16
//             out_ovf     - head result was saturated
//             level       - FIFO occupancy
//             sat_count   - saturated captures (EXPFN_OUTBUF_STATS_EN only)
//             drop_cycles - cycles with in_valid=1 and in_ready=0
//                           (EXPFN_OUTBUF_STATS_EN only)
//  Options  : define EXPFN_OUTBUF_STATS_EN to add the statistics counters
//  Revision : 1.0 - initial release
// ============================================================================
module expfn_out_buffer #(
  parameter int LATENCY   = 4,   // upstream pipeline depth, >= 1
  parameter int DEPTH     = 8,   // FIFO entries, power of two, >= 2
  parameter int FRAC_BITS = 16   // fractional bits of exp_out and out_data
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FRAC_BITS+30:0]         exp_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FRAC_BITS+15:0]         out_data,
  output logic                          out_ovf,
`ifdef EXPFN_OUTBUF_STATS_EN
  output logic [15:0]                   sat_count,
  output logic [15:0]                   drop_cycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0]    level
);

  localparam int C_LW = $clog2(DEPTH + 1);   // level width
  localparam int C_PW = $clog2(DEPTH);       // pointer width
  localparam int C_DW = FRAC_BITS + 16;      // output data width
  localparam int C_IW = FRAC_BITS + 31;      // input data width

  localparam logic [C_LW-1:0] C_FULL    = C_LW'(DEPTH);
  localparam logic [C_DW-1:0] C_SAT_MAX = {1'b0, {(C_DW-1){1'b1}}};

  logic [LATENCY-1:0] r_vsr;
  logic [C_PW-1:0]    r_wr_ptr;
  logic [C_PW-1:0]    r_rd_ptr;
  logic [C_LW-1:0]    r_level;
  logic [C_DW:0]      r_mem [DEPTH];
  logic [C_DW:0]      r_last;           // last popped head, shown when empty

  logic               w_in_ready;
  logic               w_accept;
  logic               w_capture;
  logic               w_pop;
  logic               w_out_valid;
  logic [31:0]        w_inflight;
  logic [31:0]        w_credit_used;
  logic               w_ovf;
  logic [C_DW-1:0]    w_sat_data;
  logic [C_DW:0]      w_head;

  // --------------------------------------------------------------------------
  // Credit: every sample already in the pipeline owns a FIFO slot. The capture
  // stage vsr[LATENCY-1] is counted as in flight until it lands in level, so
  // nothing is double counted. A pop frees its slot only once level is
  // updated, which keeps this path purely registered.
  // --------------------------------------------------------------------------
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + {31'd0, r_vsr[i]};
    end
  end

  assign w_credit_used = {{(32-C_LW){1'b0}}, r_level} + w_inflight;
  // Gated by reset so the upstream sees no credit while reset is held.
  assign w_in_ready    = reset && (w_credit_used < 32'(DEPTH));
  assign w_accept      = in_valid & w_in_ready;
  assign w_capture     = r_vsr[LATENCY-1];
  assign w_out_valid   = (r_level != '0);
  assign w_pop         = w_out_valid & out_ready;

  // Saturate when any integer bit above the 15 kept bits is set.
  assign w_ovf      = (exp_out[C_IW-1:C_DW-1] != '0);
  assign w_sat_data = w_ovf ? C_SAT_MAX : {1'b0, exp_out[C_DW-2:0]};

  // Valid tracking, aligned with the upstream pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
    end
  end

  // FIFO control. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + C_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PW'(1);
        r_last   <= w_head;
      end
      case ({w_capture, w_pop})
        2'b10:   r_level <= r_level + C_LW'(1);
        2'b01:   r_level <= r_level - C_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= {w_ovf, w_sat_data};
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_head[C_DW-1:0] : r_last[C_DW-1:0];
  assign out_ovf   = w_out_valid ? w_head[C_DW]     : r_last[C_DW];
  assign level     = r_level;
  assign in_ready  = w_in_ready;

`ifdef EXPFN_OUTBUF_STATS_EN
  logic [15:0] r_sat_count;
  logic [15:0] r_drop_cycles;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sat_count   <= '0;
      r_drop_cycles <= '0;
    end else begin
      if (w_capture && w_ovf && (r_sat_count != 16'hFFFF)) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
      if (in_valid && !w_in_ready && (r_drop_cycles != 16'hFFFF)) begin
        r_drop_cycles <= r_drop_cycles + 16'd1;
      end
    end
  end

  assign sat_count   = r_sat_count;
  assign drop_cycles = r_drop_cycles;
`endif

  // The credit scheme must make a capture into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
                                   !(w_capture && (r_level == C_FULL)))
    else $error("expfn_out_buffer: capture with FIFO full");

endmodule
`default_nettype wire

// File: tb/tb_expfn_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expfn_out_buffer
//  Purpose  : Directed self-checking bench for expfn_out_buffer. A delay line
//             stands in for expfn_pipelined so exp_out carries the value that
//             was presented LATENCY cycles earlier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_expfn_out_buffer;

  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [46:0] exp_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [3:0]  level;
`ifdef EXPFN_OUTBUF_STATS_EN
  logic [15:0] sat_count;
  logic [15:0] drop_cycles;
`endif

  logic [46:0] x;
  logic [46:0] r_dl [LATENCY];

  int n_vec = 0;
  int n_err = 0;

  expfn_out_buffer #(
    .LATENCY   (LATENCY),
    .DEPTH     (DEPTH),
    .FRAC_BITS (16)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exp_out     (exp_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
`ifdef EXPFN_OUTBUF_STATS_EN
    .sat_count   (sat_count),
    .drop_cycles (drop_cycles),
`endif
    .level       (level)
  );

  always #5 clock = ~clock;

  // Upstream pipeline stand-in.
  always @(posedge clock) begin
    r_dl[0] <= x;
    for (int i = 1; i < LATENCY; i++) r_dl[i] <= r_dl[i-1];
  end
  assign exp_out = r_dl[LATENCY-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Overflow/boundary table: exp_out, expected data, expected ovf.
  logic [46:0] tv_x   [4] = '{47'h0000_8000_0000, 47'h0000_7FFF_FFFF,
                              47'h4000_0000_1234, 47'h0000_0000_0001};
  logic [31:0] tv_d   [4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF,
                              32'h7FFF_FFFF, 32'h0000_0001};
  logic        tv_ovf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic [31:0] q [$];
  int          accepts;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0;
    repeat (3) tick();

    // ---------------- reset state ----------------
    check("rst_out_valid", out_valid, 0);
    check("rst_level",     level,     0);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_ovf",   out_ovf,   0);
`ifdef EXPFN_OUTBUF_STATS_EN
    check("rst_sat_count",   sat_count,   0);
    check("rst_drop_cycles", drop_cycles, 0);
`endif
    reset = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();

    // ---------------- single sample (e^2) ----------------
    in_valid = 1'b1; x = 47'h0000_0007_6399;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("single_not_early", out_valid, 0);
    tick();
    check("single_valid", out_valid, 1);
    check("single_data",  out_data,  32'h0007_6399);
    check("single_ovf",   out_ovf,   0);
    check("single_level", level,     1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped_level", level,     0);
    check("single_popped_valid", out_valid, 0);

    // ---------------- saturation table ----------------
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x = tv_x[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("ovf_head_data", out_data, 32'h7FFF_FFFF);
    check("ovf_head_ovf",  out_ovf,  1);
`ifdef EXPFN_OUTBUF_STATS_EN
    check("ovf_sat_count_1", sat_count, 1);
`endif
    repeat (3) tick();
    check("ovf_level", level, 4);
`ifdef EXPFN_OUTBUF_STATS_EN
    check("ovf_sat_count_2", sat_count, 2);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sat_data_%0d", i), out_data, tv_d[i]);
      check($sformatf("sat_ovf_%0d", i),  out_ovf,  tv_ovf[i]);
      tick();
    end
    out_ready = 1'b0;
    check("sat_drained", out_valid, 0);

    // ---------------- backpressure / full ----------------
    accepts = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      x = 47'h0000_0010_0000 + 47'(accepts);
      if (in_ready) accepts++;
      tick();
    end
    in_valid = 1'b0;
    check("full_accepts", accepts,  8);
    check("full_level",   level,    8);
    check("full_ready",   in_ready, 0);
`ifdef EXPFN_OUTBUF_STATS_EN
    check("full_drop_cycles", drop_cycles, 12);
`endif

    // ---------------- drain ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_level_%0d", i), level, 8 - i);
      check($sformatf("drain_data_%0d", i), out_data, 32'h0010_0000 + 32'(i));
      tick();
      if (i == 0) check("drain_credit_back", in_ready, 1);
    end
    check("drain_empty_level", level,     0);
    check("drain_empty_valid", out_valid, 0);

    // ---------------- simultaneous push and pop ----------------
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 5) begin
        check($sformatf("steady_valid_%0d", c), out_valid, 1);
        check($sformatf("steady_level_%0d", c), level, 1);
      end
      if (out_valid) begin
        if (q.size() == 0) check("steady_unexpected", out_valid, 0);
        else check($sformatf("steady_data_%0d", c), out_data, q.pop_front());
      end
      x = 47'h0000_0020_0000 + 47'(c);
      if (in_ready) q.push_back(32'h0020_0000 + 32'(c));
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("steady_tail_unexpected", out_valid, 0);
        else check($sformatf("steady_tail_%0d", c), out_data, q.pop_front());
      end
      tick();
    end
    out_ready = 1'b0;
    check("steady_all_out", q.size(), 0);
    check("steady_end_level", level, 0);

    // ---------------- reset mid-stream ----------------
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; x = 47'h0000_0030_0000 + 47'(k);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("mid_pre_level", level, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", level,     0);
    check("mid_rst_ready", in_ready,  0);
`ifdef EXPFN_OUTBUF_STATS_EN
    check("mid_rst_sat",  sat_count,   0);
    check("mid_rst_drop", drop_cycles, 0);
`endif
    tick();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("mid_no_stale_%0d", c), out_valid, 0);
    end
    in_valid = 1'b1; x = 47'h0000_0003_0000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid_new_not_early", out_valid, 0);
    tick();
    check("mid_new_valid", out_valid, 1);
    check("mid_new_data",  out_data,  32'h0003_0000);
    check("mid_new_level", level,     1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/expfn_out_buffer.md
Name: expfn_out_buffer

Overview:
Downstream companion of expfn_pipelined; consumes its 47-bit out bus.
- Tracks which pipeline slots carry real samples using a valid shift register aligned to the pipeline latency.
- Converts each valid result from unsigned Q31.16 to sign-magnitude Q15.16 with saturation, and queues it in a FIFO.
- Presents queued results on a valid/ready interface and throttles the upstream x source with credit-based in_ready, so no result is ever dropped.

Parameters:
LATENCY, 4, clock cycles from x sampled by expfn_pipelined to matching out; must be >= 1
DEPTH, 8, FIFO entries; power of two, >= 2
FRAC_BITS, 16, fractional bits in both exp_out and out_data

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  upstream asserts when x driven to expfn_pipelined this cycle is a real sample
in_ready  output  1  upstream may present a sample this cycle; accept = in_valid & in_ready
exp_out  input  47  out of expfn_pipelined, unsigned Q31.16
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer takes head this cycle
out_data  output  32  head result, sign-magnitude Q15.16; sign bit always 0
out_ovf  output  1  head result was saturated
level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): valid shift register cleared, FIFO emptied, pointers 0.
  - Reset values: out_valid=0, out_data=0, out_ovf=0, level=0, in_ready=0.
  - in_ready stays 0 while reset is asserted and is combinational afterwards.
- Valid tracking: vsr[0] <= accept; vsr[i] <= vsr[i-1]. A capture occurs in the cycle vsr[LATENCY-1]=1; exp_out is sampled at that edge.
- Credit rule: inflight = popcount(vsr[LATENCY-2:0]) + vsr[LATENCY-1].
  - in_ready = (level + inflight) < DEPTH.
  - A pop in the current cycle does NOT grant credit until the next cycle. This is conservative and keeps the path registered.
- Saturation:
  - If exp_out[46:31] != 0: stored data = 32'h7FFF_FFFF, ovf = 1.
  - Else: data = {1'b0, exp_out[30:0]}, ovf = 0.
  - No rounding; fractional bits pass unchanged.
- FIFO:
  - Registered storage of {ovf, data}; first-word fall-through, so out_data/out_ovf show the head whenever out_valid=1.
  - Pop = out_valid & out_ready.
  - Capture and pop in the same cycle: level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - out_valid = (level != 0).
  - When out_valid=0, out_data/out_ovf hold their last value; the bench must not check them.
- Full: the credit rule guarantees a capture never meets a full FIFO. In simulation, assert an error if a capture occurs with level == DEPTH.
- Empty: a pop with out_valid=0 is ignored.
- Latency: a result is visible on out_data the cycle after capture, i.e. LATENCY+1 cycles after accept.
- Reset mid-operation: in-flight and queued samples are discarded. No capture is made for samples accepted before reset.

Optional Feature:
Macro EXPFN_OUTBUF_STATS_EN.
- Defined: adds output ports sat_count[15:0] and drop_cycles[15:0].
  - sat_count increments on every capture with ovf=1.
  - drop_cycles increments on every cycle with in_valid=1 and in_ready=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single sample: LATENCY=4; accept at cycle 0; exp_out=47'h0000_0007_6399 at capture edge (e^2). Required: out_valid=1 at cycle 5, out_data=32'h0007_6399, out_ovf=0, level=1.
- Overflow: exp_out=47'h0000_8000_0000 at capture. Required: out_data=32'h7FFF_FFFF, out_ovf=1. With EXPFN_OUTBUF_STATS_EN, sat_count=1.
- Backpressure/full: out_ready=0 and in_valid=1 continuously. Required: exactly 8 accepts, then in_ready=0; level reaches 8; no capture at level 8.
- Drain:
  - From full, raise out_ready: 8 pops in order of acceptance.
  - in_ready returns 1 the cycle after the first pop.
  - level counts 8 down to 0.
- Simultaneous push and pop: steady in_valid=1 and out_ready=1. Required: level constant at 1 after fill, with one result per cycle in order.
- Reset mid-stream: reset=0 asynchronously with level=3 and 2 in flight. Required:
  - out_valid=0 and level=0 immediately.
  - After release, no stale captures.
  - First new sample appears LATENCY+1 cycles after its accept.
